// File: rtl/hc4_prog_loader_if.sv
// Valid/ready byte channel that carries framed program images into the HC4 loader.
interface hc4_prog_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/hc4_prog_loader.sv
// HC4 program loader: receives SYNC/LEN/payload/CSUM frames into a 4096x8 store,
// holds the core in reset while loading and serves instruction fetch from the same store.
module hc4_prog_loader #(
    parameter int TIMEOUT  = 65535,
    parameter int BOOT_RUN = 0
) (
    input  logic                    clk,
    input  logic                    nReset,
    hc4_prog_loader_if.slave        rx,
    input  logic [11:0]             fetch_addr,
    output logic [7:0]              fetch_data,
    output logic                    cpu_nReset,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_error
);
    localparam int         TW   = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [11:0]   len;
    logic [11:0]   addr;
    logic [7:0]    sum;
    logic [TW-1:0] idle_cnt;
    logic [7:0]    mem [4096];

    logic in_frame;
    logic accept;
    logic timed_out;

    assign in_frame    = state inside {LEN_HI, LEN_LO, DATA, CSUM};
    assign rx.rx_ready = nReset && (in_frame || (state == IDLE));
    assign accept      = rx.rx_valid && rx.rx_ready;
    assign timed_out   = in_frame && !accept && (idle_cnt == TW'(TIMEOUT - 1));
    assign load_busy   = in_frame;

    // The core samples fetch_data on the falling edge, so the read is combinational.
    assign fetch_data  = cpu_nReset ? mem[fetch_addr] : 8'h00;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (timed_out) begin
            state_next = ERROR;
        end else begin
            case (state)
                IDLE:   if (accept && (rx.rx_data == SYNC)) state_next = LEN_HI;
                LEN_HI: if (accept) state_next = (rx.rx_data[7:4] != 4'h0) ? ERROR : LEN_LO;
                LEN_LO: if (accept) state_next = DATA;
                DATA:   if (accept && (addr == len)) state_next = CSUM;
                CSUM:   if (accept) state_next = (8'(sum + rx.rx_data) == 8'h00) ? DONE : ERROR;
                DONE:   state_next = IDLE;
                ERROR:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // The idle counter only runs inside a frame; any accepted byte restarts it.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            len        <= '0;
            addr       <= '0;
            sum        <= '0;
            idle_cnt   <= '0;
            cpu_nReset <= (BOOT_RUN != 0);
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            if (!in_frame || accept) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept && (rx.rx_data == SYNC)) begin
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        cpu_nReset <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (accept) len[11:8] <= rx.rx_data[3:0];
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= rx.rx_data;
                        addr     <= '0;
                        sum      <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        sum <= sum + rx.rx_data;
                        if (addr != len) addr <= addr + 12'd1;
                    end
                end
                DONE: begin
                    load_done  <= 1'b1;
                    cpu_nReset <= 1'b1;
                end
                ERROR: begin
                    load_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Program memory is deliberately left out of reset so a mid-frame abort keeps what was written.
    always_ff @(posedge clk) begin
        if (accept && (state == DATA)) begin
            mem[addr] <= rx.rx_data;
        end
    end
endmodule

// File: tb/tb_hc4_prog_loader.sv
// Self-checking bench for hc4_prog_loader: table of frames plus hand-written
// sequences for resync, timeout, full-size frame and mid-frame reset.
module tb_hc4_prog_loader;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        nReset;
    logic [11:0] fetch_addr;
    logic [7:0]  fetch_data;
    logic        cpu_nReset;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    hc4_prog_loader_if bus ();

    hc4_prog_loader #(
        .TIMEOUT  (TIMEOUT),
        .BOOT_RUN (0)
    ) dut (
        .clk        (clk),
        .nReset     (nReset),
        .rx         (bus),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_nReset (cpu_nReset),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [0:11][7:0] bytes;
        int              nbytes;
        logic            exp_done;
        logic            exp_error;
        logic            exp_cpu;
        logic [11:0]     peek_addr;
        logic [7:0]      peek_data;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] value;
    } expect_t;

    expect_t sb[$];
    vec_t    vecs[5];
    int      n_pass  = 0;
    int      n_total = 0;

    task automatic expect_value(input string name, input logic [7:0] value);
        expect_t e;
        e.name  = name;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check_output(input logic [7:0] actual);
        expect_t e;
        n_total++;
        if (sb.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: got %02h with nothing expected", actual);
            return;
        end
        e = sb.pop_front();
        if (actual === e.value) n_pass++;
        else $display("[TB] FAIL %s: got %02h, required %02h", e.name, actual, e.value);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard        = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.rx_ready) begin
            n_total++;
            $display("[TB] FAIL rx_ready_wait: got rx_ready 0 for 100 cycles, required 1");
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic peek(input string name, input logic [11:0] a, input logic [7:0] exp);
        fetch_addr = a;
        #1;
        expect_value(name, exp);
        check_output(fetch_data);
    endtask

    task automatic check_bit(input string name, input logic actual, input logic exp);
        expect_value(name, {7'h0, exp});
        check_output({7'h0, actual});
    endtask

    // One frame from the table: flags stay clear on the CSUM accept edge and update on the next.
    task automatic apply_stimulus(input vec_t v);
        for (int i = 0; i < v.nbytes; i++) send_byte(v.bytes[i]);
        check_bit({v.name, ".done_pre"}, load_done, 1'b0);
        @(posedge clk);
        #1;
        check_bit({v.name, ".load_done"},  load_done,  v.exp_done);
        check_bit({v.name, ".load_error"}, load_error, v.exp_error);
        check_bit({v.name, ".cpu_nReset"}, cpu_nReset, v.exp_cpu);
        check_bit({v.name, ".rx_ready"},   bus.rx_ready, 1'b1);
        peek({v.name, ".fetch"}, v.peek_addr, v.peek_data);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] big_sum;
        logic [7:0] b;

        vecs[0] = '{"good", {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56, 32'h0},
                    8, 1'b1, 1'b0, 1'b1, 12'd2, 8'h33};
        vecs[1] = '{"bad_csum", {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h57, 32'h0},
                    8, 1'b0, 1'b1, 1'b0, 12'd2, 8'h00};
        vecs[2] = '{"len_hi_err", {8'h00, 8'hFF, 8'hA5, 8'h10, 64'h0},
                    4, 1'b0, 1'b1, 1'b0, 12'd0, 8'h00};
        vecs[3] = '{"a5_payload", {8'hA5, 8'h00, 8'h01, 8'hA5, 8'h5A, 8'h01, 48'h0},
                    6, 1'b1, 1'b0, 1'b1, 12'd0, 8'hA5};
        vecs[4] = '{"garbage_lead", {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h7E, 8'h82, 40'h0},
                    7, 1'b1, 1'b0, 1'b1, 12'd0, 8'h7E};

        nReset       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        fetch_addr   = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset.rx_ready",   bus.rx_ready, 1'b0);
        check_bit("reset.cpu_nReset", cpu_nReset,   1'b0);
        check_bit("reset.load_busy",  load_busy,    1'b0);
        check_bit("reset.load_done",  load_done,    1'b0);
        check_bit("reset.load_error", load_error,   1'b0);
        expect_value("reset.fetch_data", 8'h00);
        check_output(fetch_data);
        @(negedge clk);
        nReset = 1'b1;
        @(posedge clk);
        #1;
        check_bit("release.rx_ready", bus.rx_ready, 1'b1);

        for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);
        peek("good.addr3_kept", 12'd3, 8'h44);

        // Resync while the core runs, then stall inside the frame until the idle timeout fires.
        check_bit("resync.cpu_before", cpu_nReset, 1'b1);
        send_byte(8'hA5);
        check_bit("resync.cpu_after", cpu_nReset, 1'b0);
        check_bit("resync.busy",      load_busy,  1'b1);
        send_byte(8'h00);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check_bit("timeout.still_busy", load_busy, 1'b1);
        @(posedge clk);
        #1;
        check_bit("timeout.busy_drop", load_busy,    1'b0);
        check_bit("timeout.not_ready", bus.rx_ready, 1'b0);
        @(posedge clk);
        #1;
        check_bit("timeout.load_error", load_error, 1'b1);
        check_bit("timeout.cpu_held",   cpu_nReset, 1'b0);

        // Full 4096-byte frame.
        big_sum = 8'h00;
        send_byte(8'hA5);
        send_byte(8'h0F);
        send_byte(8'hFF);
        for (int k = 0; k < 4096; k++) begin
            b       = 8'(k * 7 + 3);
            big_sum = big_sum + b;
            send_byte(b);
        end
        send_byte(8'(-big_sum));
        @(posedge clk);
        #1;
        check_bit("big.load_done",  load_done,  1'b1);
        check_bit("big.cpu_nReset", cpu_nReset, 1'b1);
        peek("big.addr_fff", 12'hFFF, 8'(4095 * 7 + 3));
        peek("big.addr_800", 12'h800, 8'(2048 * 7 + 3));
        peek("big.addr_000", 12'h000, 8'h03);

        // Reset mid-DATA: frame aborts at once but the bytes already written stay.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h07);
        send_byte(8'hD0);
        send_byte(8'hD1);
        send_byte(8'hD2);
        nReset = 1'b0;
        #1;
        check_bit("abort.rx_ready",   bus.rx_ready, 1'b0);
        check_bit("abort.load_busy",  load_busy,    1'b0);
        check_bit("abort.cpu_nReset", cpu_nReset,   1'b0);
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        @(posedge clk);
        #1;
        check_bit("abort.ready_back", bus.rx_ready, 1'b1);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hC3);
        send_byte(8'h3C);
        send_byte(8'h01);
        @(posedge clk);
        #1;
        check_bit("restart.load_done",  load_done,  1'b1);
        check_bit("restart.load_error", load_error, 1'b0);
        peek("restart.addr0",   12'd0,   8'hC3);
        peek("restart.addr1",   12'd1,   8'h3C);
        peek("restart.addr2",   12'd2,   8'hD2);
        peek("restart.addrfff", 12'hFFF, 8'(4095 * 7 + 3));

        if (sb.size() != 0) begin
            n_total++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
